// File: rtl/mem_write_m2.sv
// mem_write_m2: write-side BRAM address generator for the output-stationary systolic array.
//
// Accepts skewed result columns from the array drain and produces per-bank write address,
// enable and data for N result banks. Lane 0 is addressed as results arrive; lane x repeats
// lane 0's address/enable x cycles later to match the upstream data skew.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         single-cycle drain request, honoured only in IDLE
//   in_valid      lane-0 result valid (lane x valid x cycles later)
//   in_data       per-lane result word, already skewed upstream
//   wr_addr_bram  per-bank write address
//   wr_en_bram    per-bank write enable
//   wr_data_bram  per-bank write data (in_data registered once)
//   busy          high from the cycle after an accepted start until DONE
//   done          one-cycle pulse after the last lane write
//   err           sticky protocol error (in_valid outside WRITE), cleared by accepted start

module mem_write_m2 #(
    parameter int unsigned D_W = 8,
    parameter int unsigned N   = 3,
    parameter int unsigned M   = 6,
    localparam int unsigned DEPTH = (M * M) / N,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [N-1:0][D_W-1:0]   in_data,
    output logic [N-1:0][AW-1:0]    wr_addr_bram,
    output logic [N-1:0]            wr_en_bram,
    output logic [N-1:0][D_W-1:0]   wr_data_bram,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned FCW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0]  LastAddr  = AW'(DEPTH - 1);
    localparam logic [FCW-1:0] LastFlush = FCW'(N - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StFlush, StDone} state_e;

    state_e                 state_q;
    logic [AW-1:0]          cnt_q;
    logic [FCW-1:0]         flush_q;
    logic                   accept;

    logic [N-1:0]           en_q;
    logic [N-1:0][AW-1:0]   addr_q;
    logic [N-1:0][D_W-1:0]  data_q;

    assign accept = (state_q == StWrite) && in_valid;

    // Control FSM; busy/done/err are registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flush_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StWrite;
                        cnt_q   <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                    end else if (in_valid) begin
                        err <= 1'b1;
                    end
                end
                StWrite: begin
                    if (in_valid) begin
                        // The last address is issued once; the counter then holds.
                        if (cnt_q == LastAddr) begin
                            state_q <= StFlush;
                            flush_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (in_valid) begin
                        err <= 1'b1;
                    end
                    // N cycles lets the last lane-0 write ripple to lane N-1.
                    if (flush_q == LastFlush) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                StDone: begin
                    if (in_valid) begin
                        err <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Lane skew chain: lane x is lane x-1 delayed by one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q[0]   <= accept;
            addr_q[0] <= cnt_q;
            for (int x = 1; x < N; x++) begin
                en_q[x]   <= en_q[x-1];
                addr_q[x] <= addr_q[x-1];
            end
            // Data is already skewed upstream, so one register aligns it with its enable.
            data_q <= in_data;
        end
    end

    assign wr_en_bram   = en_q;
    assign wr_addr_bram = addr_q;
    assign wr_data_bram = data_q;

endmodule
